// File: rtl/irq_request_controller.sv
`timescale 1ns/1ps
// irq_request_controller
//   Latches up to N_REQ request lines as edge-triggered pending bits, masks
//   them, picks the highest-priority unmasked pending line (bit N_REQ-1
//   highest) and offers its index to the service logic over a valid/ack
//   handshake. The serviced pending bit is cleared on ack.
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   enable_i     1 = may issue requests, 0 = issuing inhibited
//   req_i        raw request lines (synchronous to clk_i)
//   mask_i       1 = line masked (still latched, never issued)
//   irq_valid_o  issued index valid
//   irq_id_o     issued index, stable while irq_valid_o=1
//   irq_ack_i    consumer accepts the issued request
//   pending_o    current pending register
//   drop_o       1-cycle pulse: rising edge on an already-pending line
module irq_request_controller #(
  parameter int unsigned N_REQ = 8,
  parameter int unsigned ID_W  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic             irq_valid_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i,
  output logic [N_REQ-1:0] pending_o,
  output logic             drop_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic             load_id;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] req_edge;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] cand;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  id_q;
  logic             drop_q;

  assign req_edge = req_i & ~req_q;
  assign cand     = pending_q & ~mask_i;

  // Ascending scan: the last (highest) set bit overwrites lower ones.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (cand[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state_q == ISSUE && irq_ack_i) clr[id_q] = 1'b1;
  end

  always_comb begin
    state_nxt = state_q;
    load_id   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && (|cand)) begin
          state_nxt = ISSUE;
          load_id   = 1'b1;
        end
      end
      ISSUE: begin
        // Ack takes priority over an enable drop; both return to IDLE but
        // only the ack clears the pending bit (via clr).
        if (irq_ack_i || !enable_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      id_q      <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      req_q     <= req_i;
      // Set wins over clear on the same bit.
      pending_q <= (pending_q & ~clr) | req_edge;
      drop_q    <= |(req_edge & pending_q & ~clr);
      if (load_id) id_q <= sel;
    end
  end

  assign irq_valid_o = (state_q == ISSUE);
  assign irq_id_o    = id_q;
  assign pending_o   = pending_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_irq_request_controller.sv
`timescale 1ns/1ps
module tb_irq_request_controller;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic [7:0] req_i;
  logic [7:0] mask_i;
  logic       irq_valid_o;
  logic [2:0] irq_id_o;
  logic       irq_ack_i;
  logic [7:0] pending_o;
  logic       drop_o;

  int checks = 0;
  int errors = 0;

  irq_request_controller #(.N_REQ(8), .ID_W(3)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .req_i      (req_i),
    .mask_i     (mask_i),
    .irq_valid_o(irq_valid_o),
    .irq_id_o   (irq_id_o),
    .irq_ack_i  (irq_ack_i),
    .pending_o  (pending_o),
    .drop_o     (drop_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    // Build some state, then reset mid-handshake.
    req_i = 8'h01;
    tick();
    req_i = 8'h00;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1) begin
      $display("FAIL reset_pre_valid: got %b want 1", irq_valid_o); errors++;
    end
    rst_i = 1'b1;
    #1;
    checks++;
    if ({irq_valid_o, irq_id_o, pending_o, drop_o} !== 13'd0) begin
      $display("FAIL reset_async_outputs: got valid=%b id=%0d pend=%h drop=%b want all 0",
               irq_valid_o, irq_id_o, pending_o, drop_o);
      errors++;
    end
    #12;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (irq_valid_o !== 1'b0 || pending_o !== 8'h00) begin
      $display("FAIL reset_idle_after: got valid=%b pend=%h want 0 00", irq_valid_o, pending_o);
      errors++;
    end
  endtask

  task automatic test_single();
    req_i = 8'h01;
    tick();
    checks++;
    if (pending_o !== 8'h01 || irq_valid_o !== 1'b0) begin
      $display("FAIL single_T1: got pend=%h valid=%b want 01 0", pending_o, irq_valid_o);
      errors++;
    end
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd0) begin
      $display("FAIL single_T2: got valid=%b id=%0d want 1 0", irq_valid_o, irq_id_o);
      errors++;
    end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    req_i = 8'h00;
    checks++;
    if (pending_o !== 8'h00 || irq_valid_o !== 1'b0) begin
      $display("FAIL single_ack: got pend=%h valid=%b want 00 0", pending_o, irq_valid_o);
      errors++;
    end
    tick();
  endtask

  task automatic test_priority();
    logic [7:0] exp_pend;
    req_i = 8'hFF;
    tick();
    req_i = 8'h00;
    checks++;
    if (pending_o !== 8'hFF) begin
      $display("FAIL prio_pending: got %h want ff", pending_o); errors++;
    end
    tick();
    for (int k = 7; k >= 0; k--) begin
      checks++;
      if (irq_valid_o !== 1'b1 || irq_id_o !== 3'(k)) begin
        $display("FAIL prio_order: got valid=%b id=%0d want 1 %0d", irq_valid_o, irq_id_o, k);
        errors++;
      end
      irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      exp_pend = 8'((9'd1 << k) - 9'd1);
      checks++;
      if (pending_o !== exp_pend || irq_valid_o !== 1'b0) begin
        $display("FAIL prio_clear: got pend=%h valid=%b want %h 0", pending_o, irq_valid_o, exp_pend);
        errors++;
      end
      tick();
    end
    checks++;
    if (pending_o !== 8'h00 || irq_valid_o !== 1'b0) begin
      $display("FAIL prio_end: got pend=%h valid=%b want 00 0", pending_o, irq_valid_o);
      errors++;
    end
  endtask

  task automatic test_mask();
    req_i  = 8'h81;
    mask_i = 8'h80;
    tick();
    req_i = 8'h00;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd0) begin
      $display("FAIL mask_low_first: got valid=%b id=%0d want 1 0", irq_valid_o, irq_id_o);
      errors++;
    end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    tick();
    checks++;
    if (pending_o !== 8'h80 || irq_valid_o !== 1'b0) begin
      $display("FAIL mask_hold: got pend=%h valid=%b want 80 0", pending_o, irq_valid_o);
      errors++;
    end
    mask_i = 8'h00;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd7) begin
      $display("FAIL mask_release: got valid=%b id=%0d want 1 7", irq_valid_o, irq_id_o);
      errors++;
    end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    checks++;
    if (pending_o !== 8'h00) begin
      $display("FAIL mask_end: got pend=%h want 00", pending_o); errors++;
    end
  endtask

  task automatic test_enable();
    int budget;
    enable_i = 1'b0;
    req_i = 8'h0F;
    tick();
    req_i = 8'h00;
    tick();
    tick();
    checks++;
    if (irq_valid_o !== 1'b0 || pending_o !== 8'h0F) begin
      $display("FAIL enable_inhibit: got valid=%b pend=%h want 0 0f", irq_valid_o, pending_o);
      errors++;
    end
    enable_i = 1'b1;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd3) begin
      $display("FAIL enable_issue: got valid=%b id=%0d want 1 3", irq_valid_o, irq_id_o);
      errors++;
    end
    enable_i = 1'b0;
    tick();
    checks++;
    if (irq_valid_o !== 1'b0 || pending_o !== 8'h0F) begin
      $display("FAIL enable_drop: got valid=%b pend=%h want 0 0f", irq_valid_o, pending_o);
      errors++;
    end
    // Ack while idle is ignored.
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    checks++;
    if (pending_o !== 8'h0F) begin
      $display("FAIL ack_idle: got pend=%h want 0f", pending_o); errors++;
    end
    // Ack and enable drop together: ack wins.
    enable_i = 1'b1;
    tick();
    enable_i  = 1'b0;
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    checks++;
    if (pending_o !== 8'h07 || irq_valid_o !== 1'b0) begin
      $display("FAIL ack_vs_disable: got pend=%h valid=%b want 07 0", pending_o, irq_valid_o);
      errors++;
    end
    enable_i = 1'b1;
    budget = 0;
    while ((pending_o !== 8'h00 || irq_valid_o !== 1'b0) && budget < 20) begin
      if (irq_valid_o === 1'b1) irq_ack_i = 1'b1;
      tick();
      irq_ack_i = 1'b0;
      budget++;
    end
    checks++;
    if (pending_o !== 8'h00) begin
      $display("FAIL enable_drain: got pend=%h want 00 within 20 cycles", pending_o); errors++;
    end
  endtask

  task automatic test_collision();
    enable_i = 1'b0;
    req_i = 8'h04;
    tick();
    req_i = 8'h00;
    tick();
    req_i = 8'h04;
    tick();
    checks++;
    if (drop_o !== 1'b1 || pending_o !== 8'h04) begin
      $display("FAIL drop_pulse: got drop=%b pend=%h want 1 04", drop_o, pending_o);
      errors++;
    end
    tick();
    checks++;
    if (drop_o !== 1'b0 || pending_o !== 8'h04) begin
      $display("FAIL drop_level: got drop=%b pend=%h want 0 04", drop_o, pending_o);
      errors++;
    end
    req_i = 8'h00;
    enable_i = 1'b1;
    mask_i = 8'h04;
    tick();
    req_i = 8'h08;
    tick();
    req_i = 8'h00;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd3 || pending_o !== 8'h0C) begin
      $display("FAIL coll_issue: got valid=%b id=%0d pend=%h want 1 3 0c",
               irq_valid_o, irq_id_o, pending_o);
      errors++;
    end
    irq_ack_i = 1'b1;
    req_i = 8'h08;
    tick();
    irq_ack_i = 1'b0;
    req_i = 8'h00;
    checks++;
    if (pending_o !== 8'h0C || irq_valid_o !== 1'b0 || drop_o !== 1'b0) begin
      $display("FAIL coll_set_wins: got pend=%h valid=%b drop=%b want 0c 0 0",
               pending_o, irq_valid_o, drop_o);
      errors++;
    end
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd3) begin
      $display("FAIL coll_reissue: got valid=%b id=%0d want 1 3", irq_valid_o, irq_id_o);
      errors++;
    end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    mask_i = 8'h00;
    tick();
    checks++;
    if (irq_valid_o !== 1'b1 || irq_id_o !== 3'd2 || pending_o !== 8'h04) begin
      $display("FAIL coll_line2: got valid=%b id=%0d pend=%h want 1 2 04",
               irq_valid_o, irq_id_o, pending_o);
      errors++;
    end
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    checks++;
    if (pending_o !== 8'h00 || irq_valid_o !== 1'b0) begin
      $display("FAIL coll_end: got pend=%h valid=%b want 00 0", pending_o, irq_valid_o);
      errors++;
    end
  endtask

  initial begin
    rst_i     = 1'b1;
    enable_i  = 1'b1;
    req_i     = 8'h00;
    mask_i    = 8'h00;
    irq_ack_i = 1'b0;
    #23;
    rst_i = 1'b0;
    tick();
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_enable();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
